// File: rtl/gmii_rx_unpack_if.sv
// GMII receive byte stream in, pixel FIFO write stream and debug counters out.
// The source (PHY side / bench) uses master; gmii_rx_unpack uses slave.
interface gmii_rx_unpack_if;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [28:0] dout;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_err_cnt;

    modport master (
        output rx_dv, rx_er, rxd, fifo_full,
        input  fifo_wr_en, dout, pkt_ok_cnt, pkt_err_cnt
    );

    modport slave (
        input  rx_dv, rx_er, rxd, fifo_full,
        output fifo_wr_en, dout, pkt_ok_cnt, pkt_err_cnt
    );
endinterface

// File: rtl/gmii_rx_unpack.sv
// Parses GMII frames carrying one half-line of video and emits one
// {x, y, pixel} FIFO word per pixel, with saturating good/error frame counters.
module gmii_rx_unpack #(
    parameter int HDR_BYTES   = 42,
    parameter int PIX_PER_PKT = 640,
    parameter int Y_MAX       = 719,
    parameter int X_MAX       = 1
) (
    input  logic            clk125m,
    input  logic            reset_n,
    gmii_rx_unpack_if.slave bus
);
    localparam int BW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int PW = (PIX_PER_PKT > 1) ? $clog2(PIX_PER_PKT) : 1;
    localparam logic [BW-1:0] HDR_LAST = BW'(HDR_BYTES - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_PKT - 1);
    localparam logic [10:0]   Y_MAX_L  = 11'(Y_MAX);
    localparam logic [1:0]    X_MAX_L  = 2'(X_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TAG, S_DATA, S_TAIL, S_DROP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic [1:0]      x_q, x_d;
    logic [10:0]     y_q, y_d;
    logic            wr_en_q, wr_en_d;
    logic [28:0]     dout_q, dout_d;
    logic [15:0]     ok_cnt_q, ok_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            ok_inc, err_inc;
    logic [10:0]     tag_y;

    assign tag_y = {hi_q[2:0], bus.rxd};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        x_d        = x_q;
        y_d        = y_q;
        wr_en_d    = 1'b0;
        dout_d     = dout_q;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_dv) state_d = (bus.rxd == 8'h55) ? S_PRE : S_DROP;
            end
            S_TAIL: begin
                if (!bus.rx_dv) begin
                    ok_inc  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.rx_er) begin
                    err_inc = 1'b1;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (!bus.rx_dv) state_d = S_IDLE;
            end
            default: begin
                // Truncation and rx_er take priority over any in-frame parsing.
                if (!bus.rx_dv) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.rx_er) begin
                    err_inc = 1'b1;
                    state_d = S_DROP;
                end else begin
                    case (state_q)
                        S_PRE: begin
                            if (bus.rxd == 8'hD5) begin
                                byte_cnt_d = '0;
                                state_d    = S_HDR;
                            end else if (bus.rxd != 8'h55) begin
                                err_inc = 1'b1;
                                state_d = S_DROP;
                            end
                        end
                        S_HDR: begin
                            if (byte_cnt_q == HDR_LAST) begin
                                byte_cnt_d = '0;
                                phase_d    = 1'b0;
                                state_d    = S_TAG;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 1'b1;
                            end
                        end
                        S_TAG: begin
                            if (!phase_q) begin
                                hi_d    = bus.rxd;
                                phase_d = 1'b1;
                            end else begin
                                phase_d = 1'b0;
                                if (hi_q[7:6] > X_MAX_L || tag_y > Y_MAX_L) begin
                                    err_inc = 1'b1;
                                    state_d = S_DROP;
                                end else begin
                                    x_d       = hi_q[7:6];
                                    y_d       = tag_y;
                                    pix_cnt_d = '0;
                                    state_d   = S_DATA;
                                end
                            end
                        end
                        S_DATA: begin
                            if (!phase_q) begin
                                hi_d    = bus.rxd;
                                phase_d = 1'b1;
                            end else begin
                                phase_d = 1'b0;
                                // fifo_full is judged on the low-byte cycle that registers the write.
                                if (bus.fifo_full) begin
                                    err_inc = 1'b1;
                                    state_d = S_DROP;
                                end else begin
                                    wr_en_d   = 1'b1;
                                    dout_d    = {x_q, y_q, hi_q, bus.rxd};
                                    pix_cnt_d = pix_cnt_q + 1'b1;
                                    if (pix_cnt_q == PIX_LAST) state_d = S_TAIL;
                                end
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        ok_cnt_d  = ok_cnt_q  + {15'd0, ok_inc  && (ok_cnt_q  != '1)};
        err_cnt_d = err_cnt_q + {15'd0, err_inc && (err_cnt_q != '1)};
    end

    always_ff @(posedge clk125m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            pix_cnt_q  <= '0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            wr_en_q    <= 1'b0;
            dout_q     <= '0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            x_q        <= x_d;
            y_q        <= y_d;
            wr_en_q    <= wr_en_d;
            dout_q     <= dout_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.fifo_wr_en  = wr_en_q;
    assign bus.dout        = dout_q;
    assign bus.pkt_ok_cnt  = ok_cnt_q;
    assign bus.pkt_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_gmii_rx_unpack.sv
// Scoreboard bench for gmii_rx_unpack: frame stimulus pushes expected FIFO
// words; a negedge monitor pops and compares every fifo_wr_en strobe.
module tb_gmii_rx_unpack;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    logic [28:0] exp_q[$];
    logic        prev_wr;

    gmii_rx_unpack_if bus();

    gmii_rx_unpack #(
        .HDR_BYTES(42),
        .PIX_PER_PKT(640),
        .Y_MAX(719),
        .X_MAX(1)
    ) dut (
        .clk125m(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected word and never follow another write.
    initial prev_wr = 1'b0;
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got dout %0h, expected no write", bus.dout);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e || prev_wr) begin
                    n_bad++;
                    $display("FAIL write_word: got dout %0h (prev_wr %0b), expected %0h (prev_wr 0)",
                             bus.dout, prev_wr, e);
                end
            end
        end
        prev_wr = (bus.fifo_wr_en === 1'b1);
    end

    task automatic drive(input logic dv, input logic er, input logic [7:0] b, input logic full);
        @(posedge clk);
        #1;
        bus.rx_dv     = dv;
        bus.rx_er     = er;
        bus.rxd       = b;
        bus.fifo_full = full;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Send one frame. exp_w: number of leading pixels expected to reach the FIFO.
    task automatic frame(input logic [15:0] tag, input int npix, input int exp_w,
                         input int full_at, input bit er_hdr, input int rst_at,
                         input logic [15:0] salt, input bit fcs);
        logic [1:0]  x;
        logic [10:0] y;
        logic [15:0] px;
        x = tag[15:14];
        y = tag[10:0];
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'hD5, 1'b0);
        for (int i = 0; i < 42; i++) drive(1'b1, er_hdr && (i == 10), 8'(i), 1'b0);
        drive(1'b1, 1'b0, tag[15:8], 1'b0);
        drive(1'b1, 1'b0, tag[7:0], 1'b0);
        for (int n = 0; n < npix; n++) begin
            px = 16'(n) + salt;
            drive(1'b1, 1'b0, px[15:8], n == full_at);
            if (rst_at >= 0 && n == rst_at) begin
                // Past the negedge that saw the previous pixel's strobe; wr_en is still high here.
                #5;
                reset_n = 1'b0;
                #1;
                check("rst_async_wr_en", 32'(bus.fifo_wr_en), 32'd0);
                check("rst_async_dout", 32'(bus.dout), 32'd0);
                check("rst_async_ok", 32'(bus.pkt_ok_cnt), 32'd0);
                check("rst_async_err", 32'(bus.pkt_err_cnt), 32'd0);
            end
            if (rst_at >= 0 && n == rst_at + 10) begin
                #5;
                reset_n = 1'b1;
            end
            drive(1'b1, 1'b0, px[7:0], n == full_at);
            if (n < exp_w) exp_q.push_back({x, y, px});
        end
        if (fcs) for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'hC3, 1'b0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset_n       = 1'b0;
        bus.rx_dv     = 1'b0;
        bus.rx_er     = 1'b0;
        bus.rxd       = 8'h00;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("reset_dout", 32'(bus.dout), 32'd0);
        check("reset_ok", 32'(bus.pkt_ok_cnt), 32'd0);
        check("reset_err", 32'(bus.pkt_err_cnt), 32'd0);
        #2 reset_n = 1'b1;
        idle(3);

        // 1: basic frame x=0 y=5, pixels 0..639
        frame(16'h0005, 640, 640, -1, 1'b0, -1, 16'h0000, 1'b1);
        idle(3);
        check("t1_ok", 32'(bus.pkt_ok_cnt), 32'd1);
        check("t1_err", 32'(bus.pkt_err_cnt), 32'd0);
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // 2: x=1 y=719 then x=0 y=0 with a single idle cycle between
        frame(16'h42CF, 640, 640, -1, 1'b0, -1, 16'h1234, 1'b1);
        idle(1);
        frame(16'h0000, 640, 640, -1, 1'b0, -1, 16'hF700, 1'b1);
        idle(3);
        check("t2_ok", 32'(bus.pkt_ok_cnt), 32'd3);
        check("t2_err", 32'(bus.pkt_err_cnt), 32'd0);
        check("t2_drain", 32'(exp_q.size()), 32'd0);

        // 3: y=720 rejected, following good frame accepted
        frame(16'h02D0, 640, 0, -1, 1'b0, -1, 16'h0000, 1'b1);
        idle(2);
        check("t3_err", 32'(bus.pkt_err_cnt), 32'd1);
        frame(16'h0064, 640, 640, -1, 1'b0, -1, 16'h0100, 1'b1);
        idle(3);
        check("t3_ok", 32'(bus.pkt_ok_cnt), 32'd4);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // 4: rx_dv drops after 100 pixels
        frame(16'h4010, 100, 100, -1, 1'b0, -1, 16'h0000, 1'b0);
        idle(3);
        check("t4_err", 32'(bus.pkt_err_cnt), 32'd2);
        check("t4_ok", 32'(bus.pkt_ok_cnt), 32'd4);
        check("t4_drain", 32'(exp_q.size()), 32'd0);

        // 5: fifo_full at pixel 300, rx_er in header, then bad x=2
        frame(16'h0123, 640, 300, 300, 1'b0, -1, 16'h0000, 1'b1);
        idle(3);
        check("t5_full_err", 32'(bus.pkt_err_cnt), 32'd3);
        check("t5_full_drain", 32'(exp_q.size()), 32'd0);
        frame(16'h0007, 640, 0, -1, 1'b1, -1, 16'h0000, 1'b1);
        idle(3);
        check("t5_er_err", 32'(bus.pkt_err_cnt), 32'd4);
        frame(16'h8005, 640, 0, -1, 1'b0, -1, 16'h0000, 1'b1);
        idle(3);
        check("t5_badx_err", 32'(bus.pkt_err_cnt), 32'd5);
        check("t5_ok", 32'(bus.pkt_ok_cnt), 32'd4);
        check("t5_drain", 32'(exp_q.size()), 32'd0);

        // 6: async reset mid-DATA, rest of frame ignored, next frame good
        frame(16'h0200, 640, 150, -1, 1'b0, 150, 16'h0000, 1'b1);
        idle(3);
        check("t6_drop_ok", 32'(bus.pkt_ok_cnt), 32'd0);
        check("t6_drain", 32'(exp_q.size()), 32'd0);
        frame(16'h4201, 640, 640, -1, 1'b0, -1, 16'h0A00, 1'b1);
        idle(5);
        check("t6_ok", 32'(bus.pkt_ok_cnt), 32'd1);
        check("t6_err", 32'(bus.pkt_err_cnt), 32'd0);
        check("t6_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
